// File: rtl/cache_nway_pkg.sv
// Shared LC-3b memory-port types plus cache FSM states and datapath helpers.
// Cache top (cache_nway) optionally adds perf counters under CACHE_PERF_CNT_EN.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_block;
    typedef logic [1:0]   lc3b_mem_wmask;

    localparam int CACHE_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } cache_state_t;

    function automatic lc3b_word merge_word(input lc3b_word old_w,
                                            input lc3b_word new_w,
                                            input lc3b_mem_wmask wmask);
        lc3b_word res;
        res = old_w;
        if (wmask[0]) res[7:0]  = new_w[7:0];
        if (wmask[1]) res[15:8] = new_w[15:8];
        return res;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cache_nway_plru.sv
// Tree pseudo-LRU for one set: victim lookup and next-vector after an access.
// Node n has children 2n+1 (lower ways) and 2n+2 (upper ways); bit=1 means upper half is LRU.
module cache_plru #(
    parameter int WAYS = 2,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  plru_vec,
    input  logic [WAY_W-1:0] access_way,
    output logic [WAY_W-1:0] victim_way,
    output logic [WAYS-2:0]  plru_next
);

    // Padded to WAYS bits so tree nodes can be indexed with a WAY_W-bit pointer.
    logic [WAYS-1:0]  vec_ext;
    logic [WAYS-1:0]  next_ext;
    logic [WAY_W-1:0] vnode;
    logic [WAY_W-1:0] anode;
    logic             vdir;
    logic             adir;
    logic             unused_top;

    assign vec_ext = {1'b0, plru_vec};

    always_comb begin
        victim_way = '0;
        vnode      = '0;
        vdir       = 1'b0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            vdir = vec_ext[vnode];
            victim_way[WAY_W-1-lvl] = vdir;
            vnode = WAY_W'(2 * int'(vnode) + 1 + int'(vdir));
        end
    end

    always_comb begin
        next_ext = vec_ext;
        anode    = '0;
        adir     = 1'b0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            adir = access_way[WAY_W-1-lvl];
            next_ext[anode] = ~adir;
            anode = WAY_W'(2 * int'(anode) + 1 + int'(adir));
        end
    end

    assign plru_next  = next_ext[WAYS-2:0];
    assign unused_top = next_ext[WAYS-1];

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back/write-allocate cache, tree-PLRU, flop arrays.
// Define CACHE_PERF_CNT_EN to add saturating hit/miss/writeback counters.
module cache_nway
    import lc3b_types::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_mem_wmask mem_byte_enable,
    input  lc3b_word      mem_address,
    input  lc3b_word      mem_wdata,
    output lc3b_word      mem_rdata,
    output logic          mem_resp,
    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_word      pmem_address,
    output lc3b_block     pmem_wdata,
    input  lc3b_block     pmem_rdata,
    input  logic          pmem_resp
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [15:0]   hit_count,
    output logic [15:0]   miss_count,
    output logic [15:0]   wb_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 16 - CACHE_OFFSET_BITS - IDX_W;
    localparam int WAY_W = $clog2(WAYS);

    cache_state_t     state_q, state_d;
    logic [WAY_W-1:0] victim_q, victim_d;

    lc3b_block        data_q  [WAYS][SETS];
    lc3b_block        data_d  [WAYS][SETS];
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [TAG_W-1:0] tag_d   [WAYS][SETS];
    logic [SETS-1:0]  valid_q [WAYS];
    logic [SETS-1:0]  valid_d [WAYS];
    logic [SETS-1:0]  dirty_q [WAYS];
    logic [SETS-1:0]  dirty_d [WAYS];
    logic [WAYS-2:0]  plru_q  [SETS];
    logic [WAYS-2:0]  plru_d  [SETS];

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       word_off;
    logic             unused_addr_bit;

    assign req_idx         = mem_address[CACHE_OFFSET_BITS +: IDX_W];
    assign req_tag         = mem_address[15 -: TAG_W];
    assign word_off        = mem_address[3:1];
    assign unused_addr_bit = mem_address[0];

    logic [WAYS-1:0]  hit_vec;
    logic [WAYS-1:0]  inv_vec;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] free_way;
    logic [WAY_W-1:0] plru_victim;
    logic [WAY_W-1:0] victim_sel;
    logic [WAYS-2:0]  plru_next;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        assign hit_vec[gi] = valid_q[gi][req_idx] && (tag_q[gi][req_idx] == req_tag);
        assign inv_vec[gi] = ~valid_q[gi][req_idx];
    end

    // Descending scan leaves the lowest-numbered match / invalid way selected.
    always_comb begin
        hit_way  = '0;
        free_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_way = WAY_W'(i);
            if (inv_vec[i]) free_way = WAY_W'(i);
        end
    end

    assign hit        = |hit_vec;
    assign victim_sel = (|inv_vec) ? free_way : plru_victim;

    cache_plru #(.WAYS(WAYS)) u_plru (
        .plru_vec   (plru_q[req_idx]),
        .access_way (hit_way),
        .victim_way (plru_victim),
        .plru_next  (plru_next)
    );

    lc3b_block hit_line;
    lc3b_block merged_line;
    lc3b_word  hit_word;

    assign hit_line  = data_q[hit_way][req_idx];
    assign hit_word  = hit_line[{word_off, 4'b0} +: 16];
    assign mem_rdata = hit_word;

    always_comb begin
        merged_line = hit_line;
        merged_line[{word_off, 4'b0} +: 16] = merge_word(hit_word, mem_wdata, mem_byte_enable);
    end

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        data_d       = data_q;
        tag_d        = tag_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        plru_d       = plru_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;

        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    if (hit) begin
                        mem_resp        = 1'b1;
                        plru_d[req_idx] = plru_next;
                        if (mem_write) begin
                            data_d[hit_way][req_idx]  = merged_line;
                            dirty_d[hit_way][req_idx] = 1'b1;
                        end
                    end else begin
                        victim_d = victim_sel;
                        if (valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx])
                            state_d = WRITEBACK;
                        else
                            state_d = FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[victim_q][req_idx], req_idx, 4'b0};
                pmem_wdata   = data_q[victim_q][req_idx];
                if (pmem_resp) state_d = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_idx, 4'b0};
                if (pmem_resp) begin
                    data_d[victim_q][req_idx]  = pmem_rdata;
                    tag_d[victim_q][req_idx]   = req_tag;
                    valid_d[victim_q][req_idx] = 1'b1;
                    dirty_d[victim_q][req_idx] = 1'b0;
                    state_d                    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= '0;
            valid_q  <= '{default: '0};
            dirty_q  <= '{default: '0};
            plru_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            plru_q   <= plru_d;
        end
    end

    // Payload arrays are meaningless without their valid bits, so they skip reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

`ifdef CACHE_PERF_CNT_EN
    logic        missed_q, missed_d;
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    logic [15:0] wb_cnt_q, wb_cnt_d;

    // missed_q marks a request that has already taken a miss, so its final hit is not counted.
    always_comb begin
        missed_d   = missed_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        if (state_q == IDLE && (mem_read || mem_write) && !hit) begin
            missed_d   = 1'b1;
            miss_cnt_d = sat_inc16(miss_cnt_q);
        end
        if (mem_resp) begin
            if (!missed_q) hit_cnt_d = sat_inc16(hit_cnt_q);
            missed_d = 1'b0;
        end
        if (state_q == WRITEBACK && pmem_resp) wb_cnt_d = sat_inc16(wb_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            missed_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            missed_q   <= missed_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway: a 2-way/8-set and a 4-way/8-set instance
// share one stimulus bus, selected by sel, behind a 2-cycle memory model.
module tb_cache_nway;
    import lc3b_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          sel;
    logic          mem_read;
    logic          mem_write;
    lc3b_mem_wmask be;
    lc3b_word      addr;
    lc3b_word      wdata;
    lc3b_block     pmem_rdata;
    logic          pmem_resp;
    logic          mem_hold;

    lc3b_word  d2_rdata, d4_rdata, d2_paddr, d4_paddr;
    logic      d2_resp, d4_resp, d2_pread, d4_pread, d2_pwrite, d4_pwrite;
    lc3b_block d2_pwdata, d4_pwdata;

    lc3b_word  cur_rdata, cur_paddr;
    logic      cur_resp, cur_pread, cur_pwrite;
    lc3b_block cur_pwdata;

    assign cur_rdata  = sel ? d4_rdata  : d2_rdata;
    assign cur_resp   = sel ? d4_resp   : d2_resp;
    assign cur_pread  = sel ? d4_pread  : d2_pread;
    assign cur_pwrite = sel ? d4_pwrite : d2_pwrite;
    assign cur_paddr  = sel ? d4_paddr  : d2_paddr;
    assign cur_pwdata = sel ? d4_pwdata : d2_pwdata;

`ifdef CACHE_PERF_CNT_EN
    logic [15:0] d2_hc, d2_mc, d2_wc, d4_hc, d4_mc, d4_wc;
`endif

    cache_nway #(.WAYS(2), .SETS(8)) u_dut2 (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read & ~sel),
        .mem_write       (mem_write & ~sel),
        .mem_byte_enable (be),
        .mem_address     (addr),
        .mem_wdata       (wdata),
        .mem_rdata       (d2_rdata),
        .mem_resp        (d2_resp),
        .pmem_read       (d2_pread),
        .pmem_write      (d2_pwrite),
        .pmem_address    (d2_paddr),
        .pmem_wdata      (d2_pwdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp & ~sel)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_count       (d2_hc),
        .miss_count      (d2_mc),
        .wb_count        (d2_wc)
`endif
    );

    cache_nway #(.WAYS(4), .SETS(8)) u_dut4 (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read & sel),
        .mem_write       (mem_write & sel),
        .mem_byte_enable (be),
        .mem_address     (addr),
        .mem_wdata       (wdata),
        .mem_rdata       (d4_rdata),
        .mem_resp        (d4_resp),
        .pmem_read       (d4_pread),
        .pmem_write      (d4_pwrite),
        .pmem_address    (d4_paddr),
        .pmem_wdata      (d4_pwdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp & sel)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_count       (d4_hc),
        .miss_count      (d4_mc),
        .wb_count        (d4_wc)
`endif
    );

    int checks = 0;
    int failures = 0;

    lc3b_block mem [64];
    bit        ev_wr   [$];
    lc3b_word  ev_addr [$];
    lc3b_block ev_data [$];

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Memory model: answers a held request on its second negedge with a one-cycle pmem_resp.
    initial begin
        int wait_cnt;
        wait_cnt   = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                wait_cnt  = 0;
            end
            if (cur_pread || cur_pwrite)
                check_int("pmem_exclusive", int'(cur_pread && cur_pwrite), 0);
            if (!mem_hold && (cur_pread || cur_pwrite)) begin
                wait_cnt++;
                if (wait_cnt >= 2) begin
                    wait_cnt  = 0;
                    pmem_resp = 1'b1;
                    ev_wr.push_back(cur_pwrite);
                    ev_addr.push_back(cur_paddr);
                    ev_data.push_back(cur_pwdata);
                    if (cur_pwrite) mem[cur_paddr[9:4]] = cur_pwdata;
                    else            pmem_rdata = mem[cur_paddr[9:4]];
                    $display("pmem %s addr=%h", cur_pwrite ? "write" : "read ", cur_paddr);
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic access(input logic wr, input lc3b_word a, input lc3b_word wd,
                          input lc3b_mem_wmask m, output lc3b_word rd, output int cyc);
        @(negedge clk);
        mem_read  = ~wr;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        be        = m;
        cyc       = 0;
        #1;
        while (!cur_resp && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 100) check_int("resp_timeout", cyc, -1);
        rd = cur_rdata;
        $display("cpu %s addr=%h wdata=%h be=%b rdata=%h cycles=%0d",
                 wr ? "write" : "read ", a, wd, m, rd, cyc);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    lc3b_word rd;
    int       cyc;
    int       base;
    lc3b_word fill_addrs [3];

    initial begin
        rst       = 1'b1;
        sel       = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = '0;
        wdata     = '0;
        be        = '0;
        mem_hold  = 1'b0;
        for (int i = 0; i < 64; i++)
            for (int w = 0; w < 8; w++)
                mem[i][w*16 +: 16] = {8'(i), 8'(w)};
        mem[1][15:0]  = 16'h1234;
        mem[1][31:16] = 16'h5678;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_int("reset_resp", int'(cur_resp), 0);
        check_int("reset_pread", int'(cur_pread), 0);
        check_int("reset_pwrite", int'(cur_pwrite), 0);

        // 2-way: cold miss, then hit
        access(1'b0, 16'h0010, 16'h0, 2'b00, rd, cyc);
        check16("miss_rdata", rd, 16'h1234);
        check_int("miss_cycles", cyc, 3);
        check_int("miss_ev_count", ev_addr.size(), 1);
        check16("miss_fill_addr", ev_addr[0], 16'h0010);
        check_int("miss_fill_is_read", int'(ev_wr[0]), 0);
        access(1'b0, 16'h0010, 16'h0, 2'b00, rd, cyc);
        check16("hit_rdata", rd, 16'h1234);
        check_int("hit_cycles", cyc, 0);
        check_int("hit_no_pmem", ev_addr.size(), 1);

        // Byte-masked write hit
        access(1'b1, 16'h0012, 16'hBEEF, 2'b10, rd, cyc);
        check_int("write_hit_cycles", cyc, 0);
        access(1'b0, 16'h0012, 16'h0, 2'b00, rd, cyc);
        check16("merged_rdata", rd, 16'hBE78);
        check_int("merged_cycles", cyc, 0);

        // Fill the invalid way, then evict dirty 0x0010 (PLRU points at way0)
        access(1'b0, 16'h0090, 16'h0, 2'b00, rd, cyc);
        check_int("second_way_cycles", cyc, 3);
        check16("second_way_rdata", rd, 16'h0900);
        access(1'b0, 16'h0110, 16'h0, 2'b00, rd, cyc);
        check_int("dirty_evict_cycles", cyc, 5);
        check16("dirty_evict_rdata", rd, 16'h1100);
        check_int("dirty_evict_ev_count", ev_addr.size(), 4);
        check_int("wb_is_write", int'(ev_wr[2]), 1);
        check16("wb_addr", ev_addr[2], 16'h0010);
        check16("wb_word1", ev_data[2][31:16], 16'hBE78);
        check_int("refill_is_read", int'(ev_wr[3]), 0);
        check16("refill_addr", ev_addr[3], 16'h0110);

        // Clean victim (0x0090 in way1): straight to FILL
        access(1'b0, 16'h0190, 16'h0, 2'b00, rd, cyc);
        check_int("clean_evict_cycles", cyc, 3);
        check_int("clean_evict_ev_count", ev_addr.size(), 5);
        check_int("clean_evict_is_read", int'(ev_wr[4]), 0);

        // Reset while FILL is waiting on memory
        @(negedge clk);
        mem_hold = 1'b1;
        addr     = 16'h0210;
        mem_read = 1'b1;
        @(negedge clk);
        #1;
        check_int("fill_pending_pread", int'(cur_pread), 1);
        @(negedge clk);
        rst      = 1'b1;
        mem_read = 1'b0;
        @(negedge clk);
        #1;
        check_int("rst_fill_pread", int'(cur_pread), 0);
        check_int("rst_fill_resp", int'(cur_resp), 0);
        rst      = 1'b0;
        mem_hold = 1'b0;
        check_int("rst_fill_no_ev", ev_addr.size(), 5);
        access(1'b0, 16'h0210, 16'h0, 2'b00, rd, cyc);
        check_int("refetch_cycles", cyc, 3);
        check16("refetch_addr", ev_addr[5], 16'h0210);
        check16("refetch_rdata", rd, 16'h2100);
        access(1'b0, 16'h0012, 16'h0, 2'b00, rd, cyc);
        check_int("post_rst_miss_cycles", cyc, 3);
        check16("written_back_rdata", rd, 16'hBE78);

        // 4-way: fill all ways of set 0, then evict the dirty way0
        @(negedge clk);
        sel  = 1'b1;
        base = ev_addr.size();
        access(1'b1, 16'h0000, 16'hCAFE, 2'b11, rd, cyc);
        check_int("w4_write_cycles", cyc, 3);
        fill_addrs[0] = 16'h0080;
        fill_addrs[1] = 16'h0100;
        fill_addrs[2] = 16'h0180;
        for (int i = 0; i < 3; i++) begin
            access(1'b0, fill_addrs[i], 16'h0, 2'b00, rd, cyc);
            check_int("w4_fill_cycles", cyc, 3);
        end
        access(1'b0, 16'h0200, 16'h0, 2'b00, rd, cyc);
        check_int("w4_evict_cycles", cyc, 5);
        check16("w4_evict_rdata", rd, 16'h2000);
        check_int("w4_wb_is_write", int'(ev_wr[base+4]), 1);
        check16("w4_wb_addr", ev_addr[base+4], 16'h0000);
        check16("w4_wb_word0", ev_data[base+4][15:0], 16'hCAFE);
        check_int("w4_fill_is_read", int'(ev_wr[base+5]), 0);
        check16("w4_fill_addr", ev_addr[base+5], 16'h0200);

        // PLRU now picks clean way2 (0x0100), then way3 (0x0180)
        access(1'b0, 16'h0000, 16'h0, 2'b00, rd, cyc);
        check_int("w4_reload_cycles", cyc, 3);
        check16("w4_reload_rdata", rd, 16'hCAFE);
        check_int("w4_reload_ev_count", ev_addr.size(), base + 7);
        access(1'b0, 16'h0080, 16'h0, 2'b00, rd, cyc);
        check_int("w4_way1_hit_cycles", cyc, 0);
        access(1'b0, 16'h0100, 16'h0, 2'b00, rd, cyc);
        check_int("w4_evicted_miss_cycles", cyc, 3);
        check16("w4_evicted_rdata", rd, 16'h1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
